// File: rtl/pc_flow_controller.sv
// Program counter owner: boot vector load, FW branches, RET/RTI, interrupt entry.
// FW branch 0 extra cycles, RET 1+mem wait, IRQ 2+mem wait. Memory backpressure: mem_req held until mem_valid.
module pc_flow_controller #(
  parameter int               PC_W           = 8,
  parameter logic [PC_W-1:0]  RESET_VEC_ADDR = 8'h00,
  parameter logic [PC_W-1:0]  INT_VEC_ADDR   = 8'h01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            b_take,
  input  logic [1:0]      pc_src,
  input  logic            rti,
  input  logic [PC_W-1:0] target_fw,
  input  logic            hazard_stall,
  input  logic            irq,
  input  logic [PC_W-1:0] mem_rdata,
  input  logic            mem_valid,
  output logic [PC_W-1:0] pc,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            stall_fetch,
  output logic            int_push,
  output logic            int_ack,
  output logic            busy
);

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    RUN      = 3'd1,
    RET_WAIT = 3'd2,
    INT_SAVE = 3'd3,
    INT_VEC  = 3'd4
  } state_t;

  localparam logic [1:0] SRC_FW    = 2'b01;
  localparam logic [1:0] SRC_DATAB = 2'b10;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            irq_pending, irq_pending_nxt;
  logic            int_en, int_en_nxt;
  logic            ret_is_rti, ret_is_rti_nxt;
  logic            take_fw, take_datab;

  assign take_fw    = b_take && (pc_src == SRC_FW);
  assign take_datab = b_take && (pc_src == SRC_DATAB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= '0;
      irq_pending <= 1'b0;
      int_en      <= 1'b1;
      ret_is_rti  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      irq_pending <= irq_pending_nxt;
      int_en      <= int_en_nxt;
      ret_is_rti  <= ret_is_rti_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    int_en_nxt      = int_en;
    ret_is_rti_nxt  = ret_is_rti;
    irq_pending_nxt = irq_pending | (irq & int_en);
    mem_req         = 1'b0;
    mem_addr        = '0;
    flush_ifid      = 1'b0;
    flush_idex      = 1'b0;
    stall_fetch     = 1'b0;
    int_push        = 1'b0;
    int_ack         = 1'b0;
    busy            = (state != RUN);

    case (state)
      BOOT: begin
        mem_req     = 1'b1;
        mem_addr    = RESET_VEC_ADDR;
        stall_fetch = 1'b1;
        if (mem_valid) begin
          pc_nxt    = mem_rdata;
          state_nxt = RUN;
        end
      end

      RUN: begin
        // Branches win over stalls and pending interrupts; the irq stays latched.
        if (take_fw) begin
          pc_nxt     = target_fw;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (take_datab) begin
          flush_ifid     = 1'b1;
          flush_idex     = 1'b1;
          ret_is_rti_nxt = rti;
          state_nxt      = RET_WAIT;
        end else if (irq_pending && int_en && !hazard_stall) begin
          state_nxt = INT_SAVE;
        end else if (hazard_stall) begin
          stall_fetch = 1'b1;
        end else begin
          pc_nxt = pc + PC_W'(1);
        end
      end

      RET_WAIT: begin
        stall_fetch = 1'b1;
        if (mem_valid) begin
          pc_nxt    = mem_rdata;
          state_nxt = RUN;
          if (ret_is_rti) int_en_nxt = 1'b1;
        end
      end

      INT_SAVE: begin
        int_push    = 1'b1;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        stall_fetch = 1'b1;
        int_en_nxt  = 1'b0;
        state_nxt   = INT_VEC;
      end

      INT_VEC: begin
        mem_req     = 1'b1;
        mem_addr    = INT_VEC_ADDR;
        stall_fetch = 1'b1;
        if (mem_valid) begin
          pc_nxt          = mem_rdata;
          int_ack         = 1'b1;
          irq_pending_nxt = 1'b0;
          state_nxt       = RUN;
        end
      end

      default: state_nxt = BOOT;
    endcase
  end

endmodule
